mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Multi-cycle multiply/divide unit. It executes MIPS mult, multu, div and divu, and owns the architectural HI/LO registers.
- Sits in the EX stage beside the ALU. It takes the same forwarded operands (D1 = rs, D2 = rt).
- It provides the sequential HI/LO path that the ALU's unused control codes leave unimplemented.
- Pipeline control stalls any MD instruction (including mfhi/mflo) while `busy | start` is high.

Parameters:
- MULT_CYCLES, 5, number of cycles busy stays high for mult/multu (must be >= 1).
- DIV_CYCLES, 10, number of cycles busy stays high for div/divu (must be >= 1).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- D1  input  32  operand A (rs); dividend or multiplicand.
- D2  input  32  operand B (rt); divisor or multiplier.
- start  input  1  one-cycle strobe that launches the operation selected by MDOp.
- MDOp  input  2  operation select: 00 mult, 01 multu, 10 div, 11 divu; sampled only when start=1.
- mthi  input  1  write D1 into HI.
- mtlo  input  1  write D1 into LO.
- busy  output  1  high while an operation is in flight.
- HI  output  32  HI register value.
- LO  output  32  LO register value.

Behaviour:
- Reset: on a rising clk edge with reset=1, HI=0, LO=0, busy=0, state=IDLE, counter=0. An operation in flight is abandoned and its result is never committed.
- States:
  - IDLE (busy=0).
  - RUN (busy=1, counter counts down).
- IDLE with start=1:
  - At the edge, latch D1, D2 and MDOp. Compute the full result into internal result registers (rhi, rlo); HI and LO are not touched yet.
  - Load counter with MULT_CYCLES or DIV_CYCLES and go to RUN.
- RUN:
  - Decrement counter each edge.
  - When counter==1 at an edge: HI<=rhi, LO<=rlo, busy<=0, go to IDLE.
  - Timing: start at edge E0 means busy is high for exactly N cycles after E0, and the new HI/LO are visible in the same cycle that busy first reads 0.
- start while busy=1: ignored; no relaunch and no change to in-flight data. The pipeline guarantees this does not happen; verification checks that it is harmless.
- mthi/mtlo:
  - Honoured only in IDLE with start=0; HI (or LO) <= D1 at the edge.
  - Both asserted together: both registers get D1.
  - While busy: ignored.
  - Same cycle as start: start wins and the move is dropped.
- Arithmetic:
  - mult: signed 32x32 to a 64-bit product; HI = [63:32], LO = [31:0].
  - multu: unsigned 32x32 to a 64-bit product; same HI/LO split.
  - div: signed. LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - div special case: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (wrap, no trap).
  - divu: unsigned; LO = quotient, HI = remainder.
  - Divide by zero (div or divu with D2==0): the unit still goes busy for DIV_CYCLES, but HI and LO keep their previous values on completion.
- HI/LO are driven directly from registers with no combinational path from the inputs. Outputs change only on clk edges.
- Boundary: the cycle after busy falls, a new start is accepted, so back-to-back operations incur no dead cycle beyond the stall.

Test Plan:
- Reset mid-operation: start mult (D1=3, D2=4), assert reset on the 2nd busy cycle -> busy=0, HI=0, LO=0 next cycle; HI/LO stay 0 through the original completion time.
- mult then multu with D1=0xFFFFFFFF, D2=2:
  - mult -> busy for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
  - multu -> HI=0x00000001, LO=0xFFFFFFFE.
- Signed and unsigned divide:
  - div D1=0xFFFFFFF9 (-7), D2=2 -> busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu D1=7, D2=2 -> LO=3, HI=1.
  - div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Divide by zero: preload HI=0x1234 and LO=0x5678 via mthi/mtlo, then div with D2=0 -> busy for 10 cycles, then HI=0x1234, LO=0x5678 unchanged.
- Interference while busy: during a div, pulse start (MDOp=00) and mthi (D1=0xDEAD) -> both ignored; final HI/LO equal the div result; busy length stays 10.
- Simultaneous start+mtlo in IDLE with D1=5, D2=6, MDOp=01 -> mtlo dropped; after 5 cycles LO=30, HI=0. A follow-up mtlo with D1=9 in IDLE -> LO=9 next cycle.

Source files
------------

// File: rtl/mul_div_unit.sv
// Multi-cycle MIPS multiply/divide unit owning the architectural HI/LO registers.
// The result is computed at launch and committed to HI/LO when the busy countdown expires.
module mul_div_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] D1,
    input  logic [31:0] D2,
    input  logic        start,
    input  logic [1:0]  MDOp,
    input  logic        mthi,
    input  logic        mtlo,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] rhi_q, rhi_d;
    logic [31:0] rlo_q, rlo_d;
    logic        commit_q, commit_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic [63:0] ext_a, ext_b, prod;
    logic        neg_a, neg_b, div_zero;
    logic [31:0] mag_a, mag_b, divisor, q_mag, r_mag, quo, rem;

    // Divide on magnitudes so 0x80000000 / -1 wraps instead of overflowing.
    always_comb begin
        ext_a    = MDOp[0] ? {32'b0, D1} : {{32{D1[31]}}, D1};
        ext_b    = MDOp[0] ? {32'b0, D2} : {{32{D2[31]}}, D2};
        prod     = ext_a * ext_b;
        neg_a    = ~MDOp[0] & D1[31];
        neg_b    = ~MDOp[0] & D2[31];
        mag_a    = neg_a ? -D1 : D1;
        mag_b    = neg_b ? -D2 : D2;
        div_zero = (D2 == 32'd0);
        divisor  = div_zero ? 32'd1 : mag_b;
        q_mag    = mag_a / divisor;
        r_mag    = mag_a % divisor;
        quo      = (neg_a ^ neg_b) ? -q_mag : q_mag;
        rem      = neg_a ? -r_mag : r_mag;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rhi_d    = rhi_q;
        rlo_d    = rlo_q;
        commit_d = commit_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_RUN;
                    cnt_d    = MDOp[1] ? 32'(DIV_CYCLES) : 32'(MULT_CYCLES);
                    rhi_d    = MDOp[1] ? rem : prod[63:32];
                    rlo_d    = MDOp[1] ? quo : prod[31:0];
                    commit_d = ~(MDOp[1] & div_zero);
                end else begin
                    if (mthi) hi_d = D1;
                    if (mtlo) lo_d = D1;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - 32'd1;
                if (cnt_q == 32'd1) begin
                    state_d = ST_IDLE;
                    if (commit_q) begin
                        hi_d = rhi_q;
                        lo_d = rlo_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 32'd0;
            rhi_q    <= 32'd0;
            rlo_q    <= 32'd0;
            commit_q <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rhi_q    <= rhi_d;
            rlo_q    <= rlo_d;
            commit_q <= commit_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed scenarios plus randomized back-to-back
// operations compared against a plain-arithmetic HI/LO model.
module tb_mul_div_unit;

    localparam int MULT_C = 5;
    localparam int DIV_C  = 10;

    logic        clk = 1'b0;
    logic        reset, start, mthi, mtlo;
    logic [31:0] D1, D2;
    logic [1:0]  MDOp;
    logic        busy;
    logic [31:0] HI, LO;

    int          total = 0;
    int          bad = 0;
    logic [31:0] m_hi, m_lo;

    mul_div_unit #(.MULT_CYCLES(MULT_C), .DIV_CYCLES(DIV_C)) dut (
        .clk  (clk),
        .reset(reset),
        .D1   (D1),
        .D2   (D2),
        .start(start),
        .MDOp (MDOp),
        .mthi (mthi),
        .mtlo (mtlo),
        .busy (busy),
        .HI   (HI),
        .LO   (LO)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference result {HI, LO}; caller must not pass a zero divisor for div/divu.
    function automatic logic [63:0] ref_md(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        logic [63:0]     res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        res = 64'd0;
        case (op)
            2'b00: res = sa * sb;
            2'b01: res = ua * ub;
            2'b10: begin
                q   = sa / sb;
                r   = sa % sb;
                res = {r[31:0], q[31:0]};
            end
            default: begin
                uq  = ua / ub;
                ur  = ua % ub;
                res = {ur[31:0], uq[31:0]};
            end
        endcase
        return res;
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic with_mtlo, input string tag);
        int          n;
        int          exp_n;
        logic [63:0] r;
        exp_n = op[1] ? DIV_C : MULT_C;
        if (!(op[1] && b == 32'd0)) begin
            r    = ref_md(op, a, b);
            m_hi = r[63:32];
            m_lo = r[31:0];
        end
        D1 = a; D2 = b; MDOp = op; start = 1'b1; mtlo = with_mtlo;
        tick();
        start = 1'b0; mtlo = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            tick();
        end
        total++;
        if (n != exp_n) begin
            bad++;
            $display("FAIL %s busy_len got=%0d exp=%0d", tag, n, exp_n);
        end
        total++;
        if (HI !== m_hi) begin
            bad++;
            $display("FAIL %s HI got=%h exp=%h", tag, HI, m_hi);
        end
        total++;
        if (LO !== m_lo) begin
            bad++;
            $display("FAIL %s LO got=%h exp=%h", tag, LO, m_lo);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        total++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            bad++;
            $display("FAIL reset_state got busy=%b HI=%h LO=%h exp 0/0/0", busy, HI, LO);
        end
        // Mid-operation reset must abandon the in-flight multiply.
        D1 = 32'd3; D2 = 32'd4; MDOp = 2'b00; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            bad++;
            $display("FAIL reset_mid_op got busy=%b HI=%h LO=%h exp 0/0/0", busy, HI, LO);
        end
        for (int i = 0; i < MULT_C + 2; i++) begin
            tick();
            total++;
            if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
                bad++;
                $display("FAIL reset_hold cyc=%0d got busy=%b HI=%h LO=%h exp 0/0/0",
                         i, busy, HI, LO);
            end
        end
    endtask

    task automatic test_mult();
        run_op(2'b00, 32'hFFFF_FFFF, 32'd2, 1'b0, "mult_neg1x2");
        run_op(2'b01, 32'hFFFF_FFFF, 32'd2, 1'b0, "multu_maxx2");
    endtask

    task automatic test_div();
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_neg7_2");
        run_op(2'b11, 32'd7, 32'd2, 1'b0, "divu_7_2");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_overflow");
    endtask

    task automatic test_div_zero();
        D1 = 32'h1234; mthi = 1'b1;
        tick();
        mthi = 1'b0; D1 = 32'h5678; mtlo = 1'b1;
        tick();
        mtlo = 1'b0;
        m_hi = 32'h1234; m_lo = 32'h5678;
        total++;
        if (HI !== m_hi || LO !== m_lo) begin
            bad++;
            $display("FAIL mthi_mtlo got HI=%h LO=%h exp HI=%h LO=%h", HI, LO, m_hi, m_lo);
        end
        run_op(2'b10, 32'd100, 32'd0, 1'b0, "div_by_zero");
        run_op(2'b11, 32'd55, 32'd0, 1'b0, "divu_by_zero");
    endtask

    task automatic test_interference();
        int          n;
        logic [63:0] r;
        r    = ref_md(2'b10, 32'd100, 32'd7);
        m_hi = r[63:32];
        m_lo = r[31:0];
        D1 = 32'd100; D2 = 32'd7; MDOp = 2'b10; start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            if (n == 3) begin
                start = 1'b1; MDOp = 2'b00; mthi = 1'b1; D1 = 32'hDEAD; D2 = 32'd3;
            end else begin
                start = 1'b0; mthi = 1'b0;
            end
            tick();
        end
        start = 1'b0; mthi = 1'b0;
        total++;
        if (n != DIV_C) begin
            bad++;
            $display("FAIL interfere busy_len got=%0d exp=%0d", n, DIV_C);
        end
        total++;
        if (HI !== m_hi || LO !== m_lo) begin
            bad++;
            $display("FAIL interfere result got HI=%h LO=%h exp HI=%h LO=%h", HI, LO, m_hi, m_lo);
        end
    endtask

    task automatic test_start_mtlo();
        run_op(2'b01, 32'd5, 32'd6, 1'b1, "start_with_mtlo");
        D1 = 32'd9; mtlo = 1'b1;
        tick();
        mtlo = 1'b0;
        m_lo = 32'd9;
        total++;
        if (LO !== m_lo || HI !== m_hi) begin
            bad++;
            $display("FAIL mtlo_idle got HI=%h LO=%h exp HI=%h LO=%h", HI, LO, m_hi, m_lo);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 16; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            if ($urandom_range(0, 3) == 0) a = {a[31], 31'($urandom_range(0, 50))};
            run_op(op, a, b, 1'b0, "rand_b2b");
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        D1 = 32'd0; D2 = 32'd0; MDOp = 2'b00;
        m_hi = 32'd0; m_lo = 32'd0;
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_interference();
        test_start_mtlo();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
